// File: rtl/regfile_wb_sequencer.sv
// rtl/regfile_wb_sequencer.sv - register file write-back arbiter, in-order FIFO and forwarding
// Two request sources share one FIFO that drains one entry per cycle into the RF write port.
module regfile_wb_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                     Clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [ADDR_W-1:0]        alu_addr,
  input  logic [DATA_W-1:0]        alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [ADDR_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_data,
  input  logic                     rf_hold,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_addressIn,
  output logic [DATA_W-1:0]        rf_regIn,
  input  logic [ADDR_W-1:0]        fwd_addrA,
  output logic                     fwd_hitA,
  output logic [DATA_W-1:0]        fwd_dataA,
  input  logic [ADDR_W-1:0]        fwd_addrB,
  output logic                     fwd_hitB,
  output logic [DATA_W-1:0]        fwd_dataB,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              rr_q, rr_d;

  logic              pop, space, push;
  logic              grant_alu, grant_mem, alu_xfer, mem_xfer;
  logic [ADDR_W-1:0] push_addr;
  logic [DATA_W-1:0] push_data;
  logic [PTR_W-1:0]  idx;

  always_comb begin
    pop       = (count_q != '0) & ~rf_hold;
    space     = (count_q < CNT_W'(DEPTH)) | pop;
    // rr_q=0 favours the ALU when both sources request
    grant_alu = alu_valid & (~mem_valid | ~rr_q);
    grant_mem = mem_valid & (~alu_valid | rr_q);
    alu_ready = reset & space & grant_alu;
    mem_ready = reset & space & grant_mem;
    alu_xfer  = alu_valid & alu_ready;
    mem_xfer  = mem_valid & mem_ready;
    push_addr = alu_xfer ? alu_addr : mem_addr;
    push_data = alu_xfer ? alu_data : mem_data;
    // $zero writes complete the handshake but never occupy an entry
    push      = (alu_xfer | mem_xfer) & (push_addr != '0);

    head_d  = pop  ? head_q + PTR_W'(1) : head_q;
    tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    rr_d    = (alu_xfer | mem_xfer) ? ~rr_q : rr_q;
    vld_d   = vld_q;
    if (pop)  vld_d[head_q] = 1'b0;
    if (push) vld_d[tail_q] = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      rr_q    <= 1'b0;
      vld_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      rr_q    <= rr_d;
      vld_q   <= vld_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (reset && push) begin
      addr_q[tail_q] <= push_addr;
      data_q[tail_q] <= push_data;
    end
  end

  assign rf_we        = pop;
  assign rf_addressIn = (count_q != '0) ? addr_q[head_q] : '0;
  assign rf_regIn     = (count_q != '0) ? data_q[head_q] : '0;
  assign count        = count_q;

  // Walk oldest to youngest so the last match is the youngest pending write
  always_comb begin
    fwd_hitA  = 1'b0;
    fwd_dataA = '0;
    fwd_hitB  = 1'b0;
    fwd_dataB = '0;
    idx       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (vld_q[idx] && (fwd_addrA != '0) && (addr_q[idx] == fwd_addrA)) begin
        fwd_hitA  = 1'b1;
        fwd_dataA = data_q[idx];
      end
      if (vld_q[idx] && (fwd_addrB != '0) && (addr_q[idx] == fwd_addrB)) begin
        fwd_hitB  = 1'b1;
        fwd_dataB = data_q[idx];
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_sequencer.sv
// tb/tb_regfile_wb_sequencer.sv - directed self-checking bench for regfile_wb_sequencer
module tb_regfile_wb_sequencer;

  logic        Clk = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready, mem_valid, mem_ready, rf_hold, rf_we;
  logic [3:0]  alu_addr, mem_addr, rf_addressIn, fwd_addrA, fwd_addrB;
  logic [31:0] alu_data, mem_data, rf_regIn, fwd_dataA, fwd_dataB;
  logic        fwd_hitA, fwd_hitB;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  regfile_wb_sequencer #(.DATA_W(32), .ADDR_W(4), .DEPTH(4)) dut (
    .Clk(Clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .rf_hold(rf_hold), .rf_we(rf_we), .rf_addressIn(rf_addressIn), .rf_regIn(rf_regIn),
    .fwd_addrA(fwd_addrA), .fwd_hitA(fwd_hitA), .fwd_dataA(fwd_dataA),
    .fwd_addrB(fwd_addrB), .fwd_hitB(fwd_hitB), .fwd_dataB(fwd_dataB),
    .count(count)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_addr = 0; alu_data = 0;
    mem_valid = 0; mem_addr = 0; mem_data = 0;
    rf_hold = 0; fwd_addrA = 0; fwd_addrB = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 0;
    step(); step();
    reset = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 0;
    step();
    alu_valid = 1; alu_addr = 4'd3; alu_data = 32'h1234_5678;
    mem_valid = 1; mem_addr = 4'd2; mem_data = 32'h5555_AAAA;
    step();
    total++;
    if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
      bad++; $display("FAIL reset_ready got alu=%b mem=%b want 0 0", alu_ready, mem_ready);
    end
    total++;
    if (count !== 3'd0 || rf_we !== 1'b0 || rf_addressIn !== 4'd0 || rf_regIn !== 32'd0) begin
      bad++; $display("FAIL reset_outputs got count=%0d we=%b addr=%0d data=%h want 0 0 0 0",
                      count, rf_we, rf_addressIn, rf_regIn);
    end
    step();
    total++;
    if (count !== 3'd0) begin
      bad++; $display("FAIL reset_no_push got count=%0d want 0", count);
    end
    idle_inputs();
    fwd_addrA = 4'd3; fwd_addrB = 4'd2;
    #1;
    total++;
    if (fwd_hitA !== 1'b0 || fwd_hitB !== 1'b0 || fwd_dataA !== 32'd0 || fwd_dataB !== 32'd0) begin
      bad++; $display("FAIL reset_fwd got hitA=%b hitB=%b dA=%h dB=%h want 0 0 0 0",
                      fwd_hitA, fwd_hitB, fwd_dataA, fwd_dataB);
    end
    reset = 1;
    step();
  endtask

  task automatic test_single_write();
    do_reset();
    alu_valid = 1; alu_addr = 4'd3; alu_data = 32'hABAB_FFFF;
    #1;
    total++;
    if (alu_ready !== 1'b1) begin
      bad++; $display("FAIL single_ready got %b want 1", alu_ready);
    end
    step();
    alu_valid = 0;
    #1;
    total++;
    if (rf_we !== 1'b1 || rf_addressIn !== 4'd3 || rf_regIn !== 32'hABAB_FFFF || count !== 3'd1) begin
      bad++; $display("FAIL single_write got we=%b addr=%0d data=%h count=%0d want 1 3 ababffff 1",
                      rf_we, rf_addressIn, rf_regIn, count);
    end
    step();
    total++;
    if (count !== 3'd0 || rf_we !== 1'b0) begin
      bad++; $display("FAIL single_drain got count=%0d we=%b want 0 0", count, rf_we);
    end
  endtask

  task automatic test_arbitration();
    do_reset();
    alu_valid = 1; alu_addr = 4'd5;  alu_data = 32'h1516_1718;
    mem_valid = 1; mem_addr = 4'd15; mem_data = 32'h0045_AB7F;
    #1;
    total++;
    if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin
      bad++; $display("FAIL arb_first got alu=%b mem=%b want 1 0", alu_ready, mem_ready);
    end
    step();
    alu_valid = 0;
    #1;
    total++;
    if (mem_ready !== 1'b1 || rf_we !== 1'b1 || rf_addressIn !== 4'd5 || rf_regIn !== 32'h1516_1718) begin
      bad++; $display("FAIL arb_second got mready=%b we=%b addr=%0d data=%h want 1 1 5 15161718",
                      mem_ready, rf_we, rf_addressIn, rf_regIn);
    end
    step();
    mem_valid = 0;
    #1;
    total++;
    if (rf_we !== 1'b1 || rf_addressIn !== 4'd15 || rf_regIn !== 32'h0045_AB7F) begin
      bad++; $display("FAIL arb_mem_write got we=%b addr=%0d data=%h want 1 15 0045ab7f",
                      rf_we, rf_addressIn, rf_regIn);
    end
    step();
    total++;
    if (count !== 3'd0 || rf_we !== 1'b0) begin
      bad++; $display("FAIL arb_drain got count=%0d we=%b want 0 0", count, rf_we);
    end
  endtask

  task automatic test_full_back_to_back();
    logic [3:0]  exp_a [5];
    logic [31:0] exp_d [5];
    logic [2:0]  exp_c [5];
    exp_a = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd6};
    exp_d = '{32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 32'hA000_0004, 32'hA000_0006};
    exp_c = '{3'd4, 3'd4, 3'd3, 3'd2, 3'd1};
    do_reset();
    rf_hold = 1;
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1; alu_addr = exp_a[i]; alu_data = exp_d[i];
      step();
    end
    alu_valid = 1; alu_addr = exp_a[4]; alu_data = exp_d[4];
    mem_valid = 1; mem_addr = 4'd9; mem_data = 32'hDEAD_0009;
    #1;
    total++;
    if (count !== 3'd4 || alu_ready !== 1'b0 || mem_ready !== 1'b0 || rf_we !== 1'b0) begin
      bad++; $display("FAIL full_hold got count=%0d alu=%b mem=%b we=%b want 4 0 0 0",
                      count, alu_ready, mem_ready, rf_we);
    end
    mem_valid = 0;
    rf_hold = 0;
    #1;
    total++;
    if (alu_ready !== 1'b1) begin
      bad++; $display("FAIL full_pop_push_ready got %b want 1", alu_ready);
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (rf_we !== 1'b1 || rf_addressIn !== exp_a[i] || rf_regIn !== exp_d[i] || count !== exp_c[i]) begin
        bad++; $display("FAIL drain_%0d got we=%b addr=%0d data=%h count=%0d want 1 %0d %h %0d",
                        i, rf_we, rf_addressIn, rf_regIn, count, exp_a[i], exp_d[i], exp_c[i]);
      end
      step();
      alu_valid = 0;
      #1;
    end
    total++;
    if (count !== 3'd0 || rf_we !== 1'b0) begin
      bad++; $display("FAIL full_empty got count=%0d we=%b want 0 0", count, rf_we);
    end
  endtask

  task automatic test_forwarding();
    do_reset();
    rf_hold = 1;
    fwd_addrA = 4'd3; fwd_addrB = 4'd4;
    alu_valid = 1; alu_addr = 4'd3; alu_data = 32'h1111_1111;
    #1;
    total++;
    if (fwd_hitA !== 1'b0) begin
      bad++; $display("FAIL fwd_not_yet got hitA=%b want 0", fwd_hitA);
    end
    step();
    alu_data = 32'h2222_2222;
    #1;
    total++;
    if (fwd_hitA !== 1'b1 || fwd_dataA !== 32'h1111_1111) begin
      bad++; $display("FAIL fwd_old got hitA=%b dataA=%h want 1 11111111", fwd_hitA, fwd_dataA);
    end
    step();
    alu_valid = 0;
    #1;
    total++;
    if (fwd_hitA !== 1'b1 || fwd_dataA !== 32'h2222_2222 || fwd_hitB !== 1'b0 || fwd_dataB !== 32'd0) begin
      bad++; $display("FAIL fwd_youngest got hitA=%b dA=%h hitB=%b dB=%h want 1 22222222 0 0",
                      fwd_hitA, fwd_dataA, fwd_hitB, fwd_dataB);
    end
    rf_hold = 0;
    #1;
    total++;
    if (rf_we !== 1'b1 || fwd_hitA !== 1'b1 || fwd_dataA !== 32'h2222_2222) begin
      bad++; $display("FAIL fwd_during_pop got we=%b hitA=%b dA=%h want 1 1 22222222",
                      rf_we, fwd_hitA, fwd_dataA);
    end
    step(); step();
    total++;
    if (fwd_hitA !== 1'b0 || count !== 3'd0) begin
      bad++; $display("FAIL fwd_after_drain got hitA=%b count=%0d want 0 0", fwd_hitA, count);
    end
  endtask

  task automatic test_zero_addr();
    do_reset();
    alu_valid = 1; alu_addr = 4'd0; alu_data = 32'hFFFF_FFFF;
    #1;
    total++;
    if (alu_ready !== 1'b1) begin
      bad++; $display("FAIL zero_ready got %b want 1", alu_ready);
    end
    step();
    alu_valid = 0;
    #1;
    total++;
    if (rf_we !== 1'b0 || count !== 3'd0) begin
      bad++; $display("FAIL zero_no_write got we=%b count=%0d want 0 0", rf_we, count);
    end
    // The $zero transfer still advances round-robin, so MEM wins the next tie
    alu_valid = 1; alu_addr = 4'd7; mem_valid = 1; mem_addr = 4'd8;
    #1;
    total++;
    if (alu_ready !== 1'b0 || mem_ready !== 1'b1) begin
      bad++; $display("FAIL zero_rr got alu=%b mem=%b want 0 1", alu_ready, mem_ready);
    end
    idle_inputs();
    step(); step();
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    rf_hold = 1;
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1; alu_addr = 4'(i + 10); alu_data = 32'hC000_0000 + i;
      step();
    end
    alu_addr = 4'd13;
    #1;
    total++;
    if (count !== 3'd3 || alu_ready !== 1'b1) begin
      bad++; $display("FAIL mid_pending got count=%0d ready=%b want 3 1", count, alu_ready);
    end
    reset = 0;
    #1;
    total++;
    if (alu_ready !== 1'b0) begin
      bad++; $display("FAIL mid_ready_in_reset got %b want 0", alu_ready);
    end
    step();
    reset = 1;
    alu_valid = 0;
    #1;
    total++;
    if (count !== 3'd0 || rf_we !== 1'b0) begin
      bad++; $display("FAIL mid_reset got count=%0d we=%b want 0 0", count, rf_we);
    end
    rf_hold = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (rf_we !== 1'b0) begin
        bad++; $display("FAIL mid_no_write_%0d got we=%b want 0", i, rf_we);
      end
      step();
    end
  endtask

  initial begin
    idle_inputs();
    reset = 0;
    test_reset();
    test_single_write();
    test_arbitration();
    test_full_back_to_back();
    test_forwarding();
    test_zero_addr();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
